// File: rtl/dma_mem_pkg.sv
// Shared types and constants for the DMA FIR engine sample memory.
package dma_mem_pkg;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

    localparam int MAX_READ_LATENCY = 4;
    localparam logic [31:0] OOR_READ_DATA = 32'h0000_0000;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dma_sample_mem_ram.sv
// Single-port RAM with a registered read port followed by STAGES-1 extra
// output register stages, so read data lands STAGES cycles after the address.
module dma_sample_mem_ram
    import dma_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_p [STAGES];

    // Stage 0 is the array read itself; later stages only retime it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_p[0] <= mem[addr];
        for (int i = 1; i < STAGES; i++) begin
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    assign rdata = rdata_p[STAGES-1];

endmodule

// File: rtl/dma_sample_mem.sv
// Dual-port Avalon-MM sample memory over one single-port RAM: per-cycle
// arbiter, fixed-latency reads. Optional range checker: DMA_MEM_ADDR_CHECK_EN.
module dma_sample_mem
    import dma_mem_pkg::*;
#(
    parameter int          DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iAddress_Slave_Read,
    input  logic        iRead_Slave_Read,
    output logic        oWait_Slave_Read,
    output logic        oDataValid_Slave_Read,
    output logic [31:0] oReadData_Slave_Read,
    input  logic [31:0] iAddress_Slave_Write,
    input  logic [31:0] iData_Slave_Write,
    input  logic        iWrite_Slave_Write,
    output logic        oWait_Slave_Write
`ifdef DMA_MEM_ADDR_CHECK_EN
    ,
    output logic        oAddrErr
`endif
);

    localparam int IDX_W = idx_width(DEPTH);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("dma_sample_mem: READ_LATENCY out of range");
    end

    grant_e                  gnt_q, gnt_d;
    logic                    contention;
    logic                    rd_acc, wr_acc;
    logic [IDX_W-1:0]        rd_idx, wr_idx, ram_addr;
    logic                    ram_we;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             ram_rdata;
    logic [31:0]             rdata_q, rdata_d;

    // Waits depend only on the current requests and the pointer, so a lone
    // requester is never stalled and the pointer moves only under contention.
    always_comb begin
        contention        = iRead_Slave_Read & iWrite_Slave_Write;
        oWait_Slave_Read  = iRst | (contention & (gnt_q != GNT_READ));
        oWait_Slave_Write = iRst | (contention & (gnt_q != GNT_WRITE));
        rd_acc            = iRead_Slave_Read & ~oWait_Slave_Read;
        wr_acc            = iWrite_Slave_Write & ~oWait_Slave_Write;
        gnt_d             = gnt_q;
        if (contention) begin
            gnt_d = (gnt_q == GNT_READ) ? GNT_WRITE : GNT_READ;
        end
    end

    always_comb begin
        rd_idx   = IDX_W'((iAddress_Slave_Read - BASE_ADDR) >> 2);
        wr_idx   = IDX_W'((iAddress_Slave_Write - BASE_ADDR) >> 2);
        ram_addr = rd_acc ? rd_idx : wr_idx;
    end

    always_comb begin
        vld_d[0] = rd_acc;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

`ifdef DMA_MEM_ADDR_CHECK_EN
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic                    rd_ok, wr_ok;
    logic                    err_q, err_d;
    logic [READ_LATENCY-1:0] oor_q, oor_d;

    // Offsets below BASE_ADDR wrap to large unsigned values and fail the compare.
    always_comb begin
        rd_ok    = (iAddress_Slave_Read - BASE_ADDR) < SPAN;
        wr_ok    = (iAddress_Slave_Write - BASE_ADDR) < SPAN;
        ram_we   = wr_acc & wr_ok;
        err_d    = err_q | (rd_acc & ~rd_ok) | (wr_acc & ~wr_ok);
        oor_d[0] = rd_acc & ~rd_ok;
        for (int i = 1; i < READ_LATENCY; i++) begin
            oor_d[i] = oor_q[i-1];
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            err_q <= 1'b0;
            oor_q <= '0;
        end else begin
            err_q <= err_d;
            oor_q <= oor_d;
        end
    end

    assign oAddrErr = err_q;

    always_comb begin
        rdata_d = rdata_q;
        if (vld_q[READ_LATENCY-1]) begin
            rdata_d = oor_q[READ_LATENCY-1] ? OOR_READ_DATA : ram_rdata;
        end
    end
`else
    always_comb begin
        ram_we  = wr_acc;
        rdata_d = rdata_q;
        if (vld_q[READ_LATENCY-1]) begin
            rdata_d = ram_rdata;
        end
    end
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            gnt_q   <= GNT_READ;
            vld_q   <= '0;
            rdata_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
        end
    end

    // Output is taken from the hold mux so data appears in the valid cycle.
    always_comb begin
        oDataValid_Slave_Read = vld_q[READ_LATENCY-1];
        oReadData_Slave_Read  = rdata_d;
    end

    dma_sample_mem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (32),
        .STAGES (READ_LATENCY)
    ) u_ram (
        .clk   (iClk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (iData_Slave_Write),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dma_sample_mem.sv
// Scoreboard bench for dma_sample_mem: arbiter/memory model, per-cycle output checks.
module tb_dma_sample_mem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic        rd_wait, wr_wait, rd_vld;
    logic [31:0] rd_data;
    logic        addr_err;

    logic [31:0] r4_addr = '0, w4_addr = '0, w4_data = '0;
    logic        r4_req = 1'b0, w4_req = 1'b0;
    logic        r4_wait, w4_wait, r4_vld;
    logic [31:0] r4_data;
    logic        addr_err4;

    always #5 clk = ~clk;

    dma_sample_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) u_dut (
        .iClk                  (clk),
        .iRst                  (rst),
        .iAddress_Slave_Read   (rd_addr),
        .iRead_Slave_Read      (rd_req),
        .oWait_Slave_Read      (rd_wait),
        .oDataValid_Slave_Read (rd_vld),
        .oReadData_Slave_Read  (rd_data),
        .iAddress_Slave_Write  (wr_addr),
        .iData_Slave_Write     (wr_data),
        .iWrite_Slave_Write    (wr_req),
        .oWait_Slave_Write     (wr_wait)
`ifdef DMA_MEM_ADDR_CHECK_EN
        ,
        .oAddrErr              (addr_err)
`endif
    );

    dma_sample_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(4)) u_dut_l4 (
        .iClk                  (clk),
        .iRst                  (rst),
        .iAddress_Slave_Read   (r4_addr),
        .iRead_Slave_Read      (r4_req),
        .oWait_Slave_Read      (r4_wait),
        .oDataValid_Slave_Read (r4_vld),
        .oReadData_Slave_Read  (r4_data),
        .iAddress_Slave_Write  (w4_addr),
        .iData_Slave_Write     (w4_data),
        .iWrite_Slave_Write    (w4_req),
        .oWait_Slave_Write     (w4_wait)
`ifdef DMA_MEM_ADDR_CHECK_EN
        ,
        .oAddrErr              (addr_err4)
`endif
    );

`ifndef DMA_MEM_ADDR_CHECK_EN
    assign addr_err  = 1'b0;
    assign addr_err4 = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] widx(input logic [31:0] a);
        return 8'((a - BASE) >> 2);
    endfunction

    function automatic logic is_oor(input logic [31:0] a);
        return (a - BASE) >= 32'(DEPTH * 4);
    endfunction

    // Reference model state
    logic [31:0] mm [DEPTH];
    int          due_q [$];
    logic [31:0] exp_q [$];
    logic        gp = 1'b0;
    logic [31:0] last_rd = '0;
    logic        err_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic ew_r, ew_w, racc, wacc, exp_v, oor_r, oor_w;
        logic [31:0] ed;
        if (rst) begin
            chk("rst_rwait", {31'd0, rd_wait}, 32'd1);
            chk("rst_wwait", {31'd0, wr_wait}, 32'd1);
            chk("rst_rvalid", {31'd0, rd_vld}, 32'd0);
            chk("rst_rdata", rd_data, 32'd0);
`ifdef DMA_MEM_ADDR_CHECK_EN
            chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
`endif
            due_q.delete();
            exp_q.delete();
            gp      = 1'b0;
            last_rd = '0;
            err_m   = 1'b0;
        end else begin
            ew_r = rd_req & wr_req & (gp != 1'b0);
            ew_w = rd_req & wr_req & (gp == 1'b0);
            chk("rwait", {31'd0, rd_wait}, {31'd0, ew_r});
            chk("wwait", {31'd0, wr_wait}, {31'd0, ew_w});
            racc = rd_req & ~ew_r;
            wacc = wr_req & ~ew_w;
`ifdef DMA_MEM_ADDR_CHECK_EN
            chk("addr_err", {31'd0, addr_err}, {31'd0, err_m});
            oor_r = is_oor(rd_addr);
            oor_w = is_oor(wr_addr);
`else
            oor_r = 1'b0;
            oor_w = 1'b0;
`endif
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("rvalid", {31'd0, rd_vld}, {31'd0, exp_v});
            if (exp_v) begin
                ed = exp_q.pop_front();
                void'(due_q.pop_front());
                chk("rdata", rd_data, ed);
                last_rd = ed;
            end else begin
                chk("rhold", rd_data, last_rd);
            end
            if (wacc) begin
                if (oor_w) err_m = 1'b1;
                else mm[widx(wr_addr)] = wr_data;
            end
            if (racc) begin
                due_q.push_back(cyc + LAT);
                if (oor_r) begin
                    err_m = 1'b1;
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(mm[widx(rd_addr)]);
                end
            end
            if (rd_req & wr_req) gp = ~gp;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        for (int k = 0; k < 16 && !acc; k++) begin
            @(negedge clk);
            acc = ~wr_wait;
            if (!acc) begin @(posedge clk); #1; end
        end
        if (!acc) chk("wr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        logic acc;
        acc = 1'b0;
        rd_addr = a; rd_req = 1'b1;
        for (int k = 0; k < 16 && !acc; k++) begin
            @(negedge clk);
            acc = ~rd_wait;
            if (!acc) begin @(posedge clk); #1; end
        end
        if (!acc) chk("rd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic racc, wacc;
        int ra, wa;
        idle(3);
        rst = 1'b0;

        // Fill eight words, read them back in order
        for (int i = 0; i < 8; i++) do_write(BASE + 32'(4 * i), 32'h1111_0000 + 32'(i));
        for (int i = 0; i < 8; i++) do_read(BASE + 32'(4 * i));
        idle(6);

        // Contention straight after reset: R,W,R,W,R,W
        pulse_reset(2);
        ra = 0; wa = 10;
        rd_addr = BASE + 32'(4 * ra); rd_req = 1'b1;
        wr_addr = BASE + 32'(4 * wa); wr_data = 32'h2222_0000 + 32'(wa); wr_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("cont_rwait", {31'd0, rd_wait}, 32'(c % 2));
            chk("cont_wwait", {31'd0, wr_wait}, 32'(1 - c % 2));
            racc = ~rd_wait;
            wacc = ~wr_wait;
            @(posedge clk); #1;
            if (racc) ra++;
            if (wacc) wa++;
            rd_addr = BASE + 32'(4 * ra);
            wr_addr = BASE + 32'(4 * wa);
            wr_data = 32'h2222_0000 + 32'(wa);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        chk("cont_rd_count", 32'(ra), 32'd3);
        chk("cont_wr_count", 32'(wa), 32'd13);
        idle(4);
        for (int i = 10; i < 13; i++) do_read(BASE + 32'(4 * i));
        idle(4);

        // Write then read of the same word in the very next cycle
        do_write(BASE + 32'd20, 32'h0000_CAFE);
        do_read(BASE + 32'd20);
        idle(4);

        // Reset lands while reads are in flight
        rd_req = 1'b1; rd_addr = BASE;
        @(posedge clk); #1; rd_addr = BASE + 32'd4;
        @(posedge clk); #1; rd_addr = BASE + 32'd8;
        @(posedge clk); #1; rd_req = 1'b0;
        pulse_reset(3);
        idle(4);
        for (int i = 0; i < 3; i++) do_read(BASE + 32'(4 * i));
        idle(4);

        // Address one full span above base: wraps, or is rejected by the checker
        do_write(BASE + 32'h400, 32'h0000_ABCD);
        do_read(BASE);
        do_read(BASE + 32'h400);
        idle(6);
        pulse_reset(2);
        idle(2);

        // Latency-4 instance: single read must return exactly four cycles later
        w4_addr = BASE + 32'd28; w4_data = 32'h0000_7777; w4_req = 1'b1;
        @(negedge clk);
        chk("l4_wwait", {31'd0, w4_wait}, 32'd0);
        @(posedge clk); #1;
        w4_req = 1'b0;
        r4_addr = BASE + 32'd28; r4_req = 1'b1;
        @(negedge clk);
        chk("l4_rwait", {31'd0, r4_wait}, 32'd0);
        @(posedge clk); #1;
        r4_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("l4_rvalid", {31'd0, r4_vld}, (k == 4) ? 32'd1 : 32'd0);
            if (k >= 4) chk("l4_rdata", r4_data, 32'h0000_7777);
        end
        idle(2);

        chk("queue_drained", 32'(due_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
